// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display controller.
// HEX_SEG holds the active-high a..g pattern (bit 0 = a, bit 6 = g) for each
// nibble value 0..F. SEG_BLANK is the all-off pattern before polarity.
// RAW_BIT selects raw-segment mode inside a digit register.
package seg7_pkg;

   localparam int RAW_BIT = 7;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Entry 15 is listed first so that HEX_SEG[n] is the pattern for nibble n.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef logic [7:0] digit_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to seven-segment decoder (active-high pattern).
// Ports:
//   nibble  in  4 : value 0..F
//   seg     out 7 : segments g..a, bit 0 = a
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_display_ctrl.sv
// N-digit seven-segment display controller with per-digit hex/raw registers,
// leading-zero blanking, optional timed blinking and a registered segment bus.
// Optional feature: define SEG7_BLINK_EN to build the blink counter, blink
// phase and blink mask. Without it ctrl_blink is ignored and nothing blinks.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   wr_en/wr_digit/wr_data: digit register write (bit 7 = raw flag)
//   ctrl_wr/ctrl_blink/ctrl_lzb : control write (blink mask, LZB enable)
//   rd_digit/rd_data      : digit register read-back, 1-cycle latency
//   seg_out               : 7 bits per digit, digit i at [7i+6:7i]
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int BLINK_DIV  = 25_000_000,
   parameter bit ACTIVE_LOW = 1'b1,
   localparam int DAW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [DAW-1:0]          wr_digit,
   input  logic [7:0]              wr_data,
   input  logic                    ctrl_wr,
   input  logic [NUM_DIGITS-1:0]   ctrl_blink,
   input  logic                    ctrl_lzb,
   input  logic [DAW-1:0]          rd_digit,
   output logic [7:0]              rd_data,
   output logic [7*NUM_DIGITS-1:0] seg_out
);

   localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
   localparam logic [7*NUM_DIGITS-1:0] SEG_OFF_ALL = {NUM_DIGITS{SEG_OFF}};

   digit_t                  digit_q [NUM_DIGITS];
   digit_t                  digit_d [NUM_DIGITS];
   logic                    lzb_q, lzb_d;
   logic [7:0]              rd_data_q, rd_data_d;
   logic [7*NUM_DIGITS-1:0] seg_out_q, seg_out_d;
   logic [6:0]              hex_pat [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [NUM_DIGITS-1:0]   blink_on;
   logic [31:0]             wr_idx, rd_idx;

   // Widen indices so the range test also rejects codes beyond NUM_DIGITS-1
   // when NUM_DIGITS is not a power of two.
   assign wr_idx = 32'(wr_digit);
   assign rd_idx = 32'(rd_digit);

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg7_hex_decode u_dec (
         .nibble (digit_q[g][3:0]),
         .seg    (hex_pat[g])
      );
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i];
      if (wr_en && (wr_idx < 32'(NUM_DIGITS))) digit_d[wr_digit] = wr_data;
      rd_data_d = '0;
      if (rd_idx < 32'(NUM_DIGITS)) rd_data_d = digit_q[rd_digit];
      lzb_d = ctrl_wr ? ctrl_lzb : lzb_q;
   end

   // A digit stays blanked only while every digit from the top down to it is a
   // hex zero; digit 0 is excluded so the display never goes fully dark.
   always_comb begin
      logic leading;
      leading  = lzb_q;
      lz_blank = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         leading     = leading && !digit_q[i][RAW_BIT] && (digit_q[i][3:0] == 4'h0);
         lz_blank[i] = leading;
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int BCW = $clog2(BLINK_DIV);
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

   logic [BCW-1:0]        blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [NUM_DIGITS-1:0] blink_mask_q, blink_mask_d;

   always_comb begin
      blink_mask_d = ctrl_wr ? ctrl_blink : blink_mask_q;
      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d   = blink_cnt_q + BCW'(1);
         blink_phase_d = blink_phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         blink_mask_q  <= '0;
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         blink_mask_q  <= blink_mask_d;
      end
   end

   assign blink_on = blink_mask_q & {NUM_DIGITS{blink_phase_q}};
`else
   localparam int unused_blink_div = BLINK_DIV;
   logic unused_ctrl_blink;
   assign unused_ctrl_blink = ^ctrl_blink;
   assign blink_on = '0;
`endif

   always_comb begin
      logic [6:0] pat;
      pat       = SEG_BLANK;
      seg_out_d = SEG_OFF_ALL;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         pat = digit_q[i][RAW_BIT] ? digit_q[i][6:0] : hex_pat[i];
         if (lz_blank[i] || blink_on[i]) pat = SEG_BLANK;
         seg_out_d[7*i +: 7] = ACTIVE_LOW ? ~pat : pat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
         lzb_q     <= 1'b0;
         rd_data_q <= '0;
         seg_out_q <= SEG_OFF_ALL;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
         lzb_q     <= lzb_d;
         rd_data_q <= rd_data_d;
         seg_out_q <= seg_out_d;
      end
   end

   assign rd_data = rd_data_q;
   assign seg_out = seg_out_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: an 8-digit active-low instance and a 6-digit
// active-high instance share one stimulus stream; a reference model predicts
// both every cycle, and directed vectors pin hand-computed values.
module tb_seg7_display_ctrl;

   localparam int BLINK_DIV = 4;
`ifdef SEG7_BLINK_EN
   localparam bit BLINK_EN = 1'b1;
`else
   localparam bit BLINK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [2:0]  wr_digit;
   logic [7:0]  wr_data;
   logic        ctrl_wr;
   logic [7:0]  ctrl_blink;
   logic        ctrl_lzb;
   logic [2:0]  rd_digit;
   logic [7:0]  rd_a, rd_b;
   logic [55:0] seg_a;
   logic [41:0] seg_b;

   always #5 clk = ~clk;

   seg7_display_ctrl #(.NUM_DIGITS(8), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1'b1)) dut_a (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_digit(wr_digit), .wr_data(wr_data),
      .ctrl_wr(ctrl_wr), .ctrl_blink(ctrl_blink), .ctrl_lzb(ctrl_lzb),
      .rd_digit(rd_digit), .rd_data(rd_a), .seg_out(seg_a));

   seg7_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_digit(wr_digit), .wr_data(wr_data),
      .ctrl_wr(ctrl_wr), .ctrl_blink(ctrl_blink[5:0]), .ctrl_lzb(ctrl_lzb),
      .rd_digit(rd_digit), .rd_data(rd_b), .seg_out(seg_b));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [7:0]  ma [8];
   logic [7:0]  mb [8];
   logic [7:0]  m_mask;
   logic        m_lzb;
   int          k;
   logic [55:0] exp_a;
   logic [41:0] exp_b;
   logic [7:0]  exp_rd_a, exp_rd_b;
   bit          model_valid = 1'b0;

   function automatic logic [55:0] disp(input logic [7:0] d [8], input int nd, input bit al,
                                        input logic [7:0] mask, input bit lzb, input bit ph);
      int top;
      logic [6:0] p;
      logic [55:0] r;
      r   = '0;
      top = 0;
      for (int i = 0; i < nd; i++)
         if (d[i][7] || d[i][3:0] != 4'h0) top = i;
      for (int i = 0; i < nd; i++) begin
         p = d[i][7] ? d[i][6:0] : hex_tab[d[i][3:0]];
         if ((lzb && i > top) || (BLINK_EN && mask[i] && ph)) p = 7'h00;
         r[7*i +: 7] = al ? ~p : p;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      logic [55:0] tmp;
      bit ph;
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
         end
         m_mask   = 8'h00;
         m_lzb    = 1'b0;
         k        = 0;
         exp_a    = '1;
         exp_b    = '0;
         exp_rd_a = 8'h00;
         exp_rd_b = 8'h00;
      end else begin
         ph       = ((k / BLINK_DIV) % 2) == 1;
         exp_a    = disp(ma, 8, 1'b1, m_mask, m_lzb, ph);
         tmp      = disp(mb, 6, 1'b0, m_mask, m_lzb, ph);
         exp_b    = tmp[41:0];
         exp_rd_a = ma[rd_digit];
         exp_rd_b = (rd_digit < 3'd6) ? mb[rd_digit] : 8'h00;
         if (wr_en) begin
            ma[wr_digit] = wr_data;
            if (wr_digit < 3'd6) mb[wr_digit] = wr_data;
         end
         if (ctrl_wr) begin
            m_mask = ctrl_blink;
            m_lzb  = ctrl_lzb;
         end
         k++;
      end
      model_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("model_seg_a", 64'(seg_a), 64'(exp_a));
         chk("model_seg_b", 64'(seg_b), 64'(exp_b));
         chk("model_rd_a",  64'(rd_a),  64'(exp_rd_a));
         chk("model_rd_b",  64'(rd_b),  64'(exp_rd_b));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic write_digit(input logic [2:0] idx, input logic [7:0] data);
      @(negedge clk);
      wr_en    = 1'b1;
      wr_digit = idx;
      wr_data  = data;
      @(negedge clk);
      wr_en    = 1'b0;
   endtask

   task automatic write_ctrl(input logic [7:0] blink, input logic lzb);
      @(negedge clk);
      ctrl_wr    = 1'b1;
      ctrl_blink = blink;
      ctrl_lzb   = lzb;
      @(negedge clk);
      ctrl_wr    = 1'b0;
   endtask

   initial begin
      logic [3:0] lz_tab [8];
      int nbl, nbad;
      lz_tab = '{4'h0, 4'h0, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};

      reset = 1'b1; wr_en = 1'b0; wr_digit = '0; wr_data = '0;
      ctrl_wr = 1'b0; ctrl_blink = '0; ctrl_lzb = 1'b0; rd_digit = '0;

      repeat (3) @(negedge clk);
      chk("reset_seg_a", 64'(seg_a), 64'({8{7'h7F}}));
      chk("reset_seg_b", 64'(seg_b), 64'h0);
      chk("reset_rd_a",  64'(rd_a),  64'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("zero_seg_a", 64'(seg_a), 64'({8{7'h40}}));
      chk("zero_seg_b", 64'(seg_b), 64'({6{7'h3F}}));

      write_digit(3'd3, 8'h0A);
      @(negedge clk);
      chk("hex_a_digit3", 64'(seg_a[27:21]), 64'(7'h08));
      write_digit(3'd3, 8'hC9);
      @(negedge clk);
      chk("raw_digit3", 64'(seg_a[27:21]), 64'(7'h36));

      for (int i = 0; i < 8; i++) write_digit(3'(i), {4'h0, lz_tab[i]});
      write_ctrl(8'h00, 1'b1);
      @(negedge clk);
      chk("lzb_a", 64'(seg_a),
          64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40, 7'h40}));
      chk("lzb_b", 64'(seg_b), 64'({7'h00, 7'h00, 7'h06, 7'h5B, 7'h3F, 7'h3F}));

      write_digit(3'd3, 8'h00);
      write_digit(3'd2, 8'h00);
      @(negedge clk);
      chk("lzb_all0_a", 64'(seg_a), 64'({{7{7'h7F}}, 7'h40}));
      chk("lzb_all0_b", 64'(seg_b), 64'({{5{7'h00}}, 7'h3F}));

      write_ctrl(8'h01, 1'b0);
      nbl  = 0;
      nbad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (seg_a[6:0] == 7'h7F) nbl++;
         if (seg_a[13:7] != 7'h40) nbad++;
      end
      chk("blink_count_d0", 64'(nbl), BLINK_EN ? 64'd4 : 64'd0);
      chk("blink_steady_d1", 64'(nbad), 64'd0);
      write_ctrl(8'h00, 1'b0);

      write_digit(3'd2, 8'h55);
      @(negedge clk);
      wr_en = 1'b1; wr_digit = 3'd2; wr_data = 8'hAA; rd_digit = 3'd2;
      @(negedge clk);
      chk("rbw_old_a", 64'(rd_a), 64'h55);
      chk("rbw_old_b", 64'(rd_b), 64'h55);
      wr_en = 1'b0;
      @(negedge clk);
      chk("rbw_new_a", 64'(rd_a), 64'hAA);

      rd_digit = 3'd7;
      write_digit(3'd7, 8'h88);
      write_digit(3'd6, 8'h99);
      @(negedge clk);
      chk("oor_seg_b", 64'(seg_b),
          64'({7'h3F, 7'h3F, 7'h3F, 7'h2A, 7'h3F, 7'h3F}));
      chk("oor_rd_b", 64'(rd_b), 64'h0);
      chk("inr_rd_a", 64'(rd_a), 64'h88);
      chk("inr_a_digit7", 64'(seg_a[55:49]), 64'(7'h77));
      chk("inr_a_digit6", 64'(seg_a[48:42]), 64'(7'h66));

      reset = 1'b1;
      @(negedge clk);
      chk("midrst_seg_a", 64'(seg_a), 64'({8{7'h7F}}));
      chk("midrst_seg_b", 64'(seg_b), 64'h0);
      chk("midrst_rd_a",  64'(rd_a),  64'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("release_seg_a", 64'(seg_a), 64'({8{7'h40}}));
      chk("release_seg_b", 64'(seg_b), 64'({6{7'h3F}}));

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Parametrised N-digit seven-segment display controller. It replaces the fixed 32-bit `hex3_hex0`/`hex7_hex4` export-plus-inversion scheme with per-digit registers, each selectable as hex-decoded or raw segments, plus leading-zero blanking and timed per-digit blinking. It sits between the processor-side write port and the board `HEXn` pins, and drives registered segment outputs directly.

## Interface
- `NUM_DIGITS`, 8: number of digits, 1..16.
- `BLINK_DIV`, 25_000_000: `clk` cycles per blink half-period, ≥2.
- `ACTIVE_LOW`, 1: 1 inverts every segment output (board pins are active-low).
- `DAW`, `$clog2(NUM_DIGITS)` (min 1): digit address width, derived and not overridden.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: digit write strobe.
- `wr_digit` in DAW: digit index; 0 is the rightmost digit.
- `wr_data` in 8: bit 7 is the raw flag. Raw=1: bits [6:0] are segments g..a. Raw=0: bits [3:0] are a hex nibble.
- `ctrl_wr` in 1: control write strobe.
- `ctrl_blink` in NUM_DIGITS: per-digit blink mask, latched on `ctrl_wr`.
- `ctrl_lzb` in 1: leading-zero-blank enable, latched on `ctrl_wr`.
- `rd_digit` in DAW: read-back index.
- `rd_data` out 8: digit register contents, 1-cycle latency.
- `seg_out` out 7*NUM_DIGITS: digit i occupies bits [7i+6:7i]; bit 0 = segment a, bit 6 = segment g.

## Operation
- State: `digit_reg[NUM_DIGITS]` (8 b each), `blink_mask`, `lzb`, `blink_cnt`, `blink_phase`.
- Reset values:
  - `digit_reg` = 0 (hex mode, value 0); `blink_mask` = 0; `lzb` = 0; `blink_cnt` = 0; `blink_phase` = 0.
  - `rd_data` = 0.
  - `seg_out` = blank pattern (all 1 if ACTIVE_LOW, else all 0).
- Write: on `wr_en`, `digit_reg[wr_digit]` ← `wr_data`. If `wr_digit` ≥ NUM_DIGITS the write is ignored with no aliasing.
- Control write: on `ctrl_wr`, `blink_mask` ← `ctrl_blink` and `lzb` ← `ctrl_lzb`. `wr_en` and `ctrl_wr` in the same cycle both take effect.
- Per-digit pattern, before polarity:
  - Raw digit: `digit_reg[6:0]`.
  - Hex digit: decoded nibble using 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Leading-zero blanking (when `lzb`=1):
  - Scan from digit NUM_DIGITS-1 downward.
  - A digit is blanked while it and every higher digit are hex-mode with nibble 0.
  - The scan stops at the first raw digit or the first nonzero nibble.
  - Digit 0 is never blanked by LZB.
- Blink: digit i is forced blank when `blink_mask[i]`=1 and `blink_phase`=1.
- Polarity: if ACTIVE_LOW, invert the final pattern. Blank is all segments off after polarity.
- Read-back: `rd_data` ← `digit_reg[rd_digit]`, sampled before any same-cycle write (read-before-write). An out-of-range index returns 0.

## Timing
- A write or control write captured at edge N is visible on `seg_out` after edge N+1 (one output register stage).
- `rd_data` is valid after the edge following the `rd_digit` presentation.
- `blink_cnt` counts 0..BLINK_DIV-1. At wrap it returns to 0 and `blink_phase` toggles in the same edge. Blink period = 2*BLINK_DIV cycles.
- `blink_cnt` is free-running. Writing `ctrl_blink` does not restart it.
- `reset` asserted mid-operation: all state returns to its reset values at that edge. `seg_out` shows blank while `reset` is high. It shows "0" on every digit one edge after release.

## Configuration
- `SEG7_BLINK_EN` defined: the blink counter, `blink_phase` and blink masking are present.
- Not defined:
  - `blink_cnt` and `blink_phase` are not instantiated.
  - `ctrl_blink` is accepted but ignored, and `blink_mask` reads as 0.
  - No digit ever blinks.
  - All other behaviour and latencies are unchanged.

## Structure
- `seg7_pkg`:
  - 16-entry segment-pattern constant for 0..F.
  - `SEG_BLANK` constant (7'h00).
  - `RAW_BIT` index constant (7).
  - Typedef for the 8-bit digit register.
- Sub-module `seg7_hex_decode`: purely combinational, 4-bit nibble → 7-bit pattern using the package constant. Instantiated once per digit.

## Test plan
- Reset test, ACTIVE_LOW=1, NUM_DIGITS=8.
  - During reset: `seg_out` all 1.
  - Two edges after release: every digit field = ~7'h3F = 7'h40.
- Hex write, then raw write.
  - `wr_digit`=3, `wr_data`=8'h0A → digit 3 = ~7'h77 = 7'h08 one edge after capture.
  - Then `wr_data`=8'hC9 (raw, segments 7'h49) → digit 3 = 7'h36.
- Leading-zero blanking.
  - Digits 7..0 = hex 0,0,0,0,1,2,0,0; `ctrl_lzb`=1 → digits 7..4 blank; digits 3..0 show 1,2,0,0.
  - All digits = hex 0 → only digit 0 shows "0".
- Blink, with `SEG7_BLINK_EN` defined and BLINK_DIV=4.
  - `ctrl_blink`=8'h01 → digit 0 alternates shown/blank every 4 cycles; other digits stay steady.
  - Rebuild without the macro → digit 0 stays steady.
- Simultaneous write and read, same index.
  - `wr_en`, `wr_digit`=2 and `rd_digit`=2 in the same cycle → `rd_data` returns the old value.
  - The next read returns the new value.
- Out-of-range write: NUM_DIGITS=6, `wr_digit`=7 → no digit register changes and `seg_out` is unchanged.
